// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the MEM stage and MEM/WB register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_wb_pkg;

    localparam int DATA_W             = 32;
    localparam int REG_W              = 5;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    // Data-memory access sequencer states.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
// Latency: n/a (wires only).
// Backpressure: the slave holds off completion by keeping DAck low while DReq is high.
interface mem_wb_stage_if;
    import mem_wb_pkg::*;

    logic              DReq;
    logic              DWe;
    logic [DATA_W-1:0] DAddr;
    logic [DATA_W-1:0] DWData;
    logic [DATA_W-1:0] DRData;
    logic              DAck;

    modport master (
        output DReq, DWe, DAddr, DWData,
        input  DRData, DAck
    );

    modport slave (
        input  DReq, DWe, DAddr, DWData,
        output DRData, DAck
    );

endinterface

// File: rtl/mem_wait_counter.sv
// Saturating wait counter with clear, enable and a terminal-count flag.
// Latency: Tc is combinational; it is high in the cycle whose increment reaches Max.
// Backpressure: none; Clear has priority over Enable.
module mem_wait_counter #(
    parameter int Max = 16,
    parameter int W   = 5
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Clear,
    input  logic Enable,
    output logic Tc
);

    logic [W-1:0] count;

    // Count enabled cycles, holding at Max until cleared.
    always_ff @(posedge Clk) begin
        if (!Rst_n || Clear) begin
            count <= '0;
        end else if (Enable && (count != W'(Max))) begin
            count <= count + 1'b1;
        end
    end

    // This cycle's increment lands on Max.
    always_comb begin
        Tc = Enable && (count == W'(Max - 1));
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage load/store sequencer plus MEM/WB pipeline register. Optional macro: MEM_WB_TIMEOUT_EN.
// Latency: non-memory ops 1 cycle; memory ops k+1 cycles when DAck arrives in the k-th REQ cycle.
// Backpressure: Stall holds the upstream pipeline while an access is outstanding.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              MEMRegWrite,
    input  logic              MEMMemtoReg,
    input  logic              MEMMemWrite,
    input  logic              MEMMemRead,
    input  logic [DATA_W-1:0] MEMALUResult,
    input  logic [DATA_W-1:0] MEMRegData2,
    input  logic [REG_W-1:0]  MEMRegisterRd,
    mem_wb_stage_if.master    dmem,
    output logic              Stall,
    output logic              WBRegWrite,
    output logic              WBMemtoReg,
    output logic [DATA_W-1:0] WBReadData,
    output logic [DATA_W-1:0] WBALUResult,
    output logic [REG_W-1:0]  WBRegisterRd,
    output logic              MemErr
);

    if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_w_check
        $error("mem_wb_stage: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_t state;
    state_t stateNxt;
    logic   memop;
    logic   issue;
    logic   complete;
    logic   passThru;
    logic   tmoFire;

    // A store wins over a load when both are flagged; either one needs the bus.
    assign memop = MEMMemRead | MEMMemWrite;

`ifdef MEM_WB_TIMEOUT_EN
    logic waitEn;
    logic waitClr;

    assign waitEn  = (state == REQ) && !dmem.DAck;
    assign waitClr = (state != REQ) || dmem.DAck || tmoFire;

    mem_wait_counter #(
        .Max (TIMEOUT_CYCLES),
        .W   (CNT_W)
    ) u_wait (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Clear  (waitClr),
        .Enable (waitEn),
        .Tc     (tmoFire)
    );
`else
    assign tmoFire = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Next state, stall and the datapath load strobes.
    always_comb begin
        stateNxt = state;
        Stall    = 1'b0;
        issue    = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    Stall    = 1'b1;
                    issue    = 1'b1;
                    stateNxt = REQ;
                end
            end
            REQ: begin
                // An ack in the timeout cycle still counts as a normal completion.
                if (dmem.DAck) begin
                    complete = 1'b1;
                    stateNxt = IDLE;
                end else if (tmoFire) begin
                    stateNxt = IDLE;
                end else begin
                    Stall = 1'b1;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign passThru = ((state == IDLE) && !memop) || complete;

    // Memory bus registers, MEM/WB register and error pulse.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            dmem.DReq    <= 1'b0;
            dmem.DWe     <= 1'b0;
            dmem.DAddr   <= '0;
            dmem.DWData  <= '0;
            WBRegWrite   <= 1'b0;
            WBMemtoReg   <= 1'b0;
            WBReadData   <= '0;
            WBALUResult  <= '0;
            WBRegisterRd <= '0;
            MemErr       <= 1'b0;
        end else begin
            MemErr <= tmoFire;

            if (issue) begin
                dmem.DReq   <= 1'b1;
                dmem.DWe    <= MEMMemWrite;
                dmem.DAddr  <= MEMALUResult;
                dmem.DWData <= MEMRegData2;
            end else if (complete || tmoFire) begin
                dmem.DReq <= 1'b0;
            end

            // Any cycle that is not a pass-through emits a bubble so the
            // instruction waiting on memory is written back exactly once.
            if (passThru) begin
                WBRegWrite   <= MEMRegWrite;
                WBMemtoReg   <= MEMMemtoReg;
                WBALUResult  <= MEMALUResult;
                WBRegisterRd <= MEMRegisterRd;
                if (complete && !dmem.DWe) begin
                    WBReadData <= dmem.DRData;
                end
            end else begin
                WBRegWrite <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases then randomized ops with random memory latency.
// Latency: checks k stall cycles and WB results k+1 cycles after an op enters MEM.
// Backpressure: bench plays data memory and holds MEM inputs stable while Stall is high.
module tb_mem_wb_stage;
    import mem_wb_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        MEMRegWrite, MEMMemtoReg, MEMMemWrite, MEMMemRead;
    logic [31:0] MEMALUResult, MEMRegData2;
    logic [4:0]  MEMRegisterRd;
    logic        Stall, WBRegWrite, WBMemtoReg, MemErr;
    logic [31:0] WBReadData, WBALUResult;
    logic [4:0]  WBRegisterRd;

    mem_wb_stage_if dmem ();

    always #5 Clk = ~Clk;

    mem_wb_stage #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (5)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .MEMRegWrite   (MEMRegWrite),
        .MEMMemtoReg   (MEMMemtoReg),
        .MEMMemWrite   (MEMMemWrite),
        .MEMMemRead    (MEMMemRead),
        .MEMALUResult  (MEMALUResult),
        .MEMRegData2   (MEMRegData2),
        .MEMRegisterRd (MEMRegisterRd),
        .dmem          (dmem),
        .Stall         (Stall),
        .WBRegWrite    (WBRegWrite),
        .WBMemtoReg    (WBMemtoReg),
        .WBReadData    (WBReadData),
        .WBALUResult   (WBALUResult),
        .WBRegisterRd  (WBRegisterRd),
        .MemErr        (MemErr)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [4:0]  rd;
    } wb_t;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mRd         = '0;   // architectural model of the WB load-data register
    wb_t         pend;
    bit          havePend    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_pending();
        if (havePend) begin
            chk("wb_regwrite", 32'(WBRegWrite), 32'(pend.rw));
            chk("wb_memtoreg", 32'(WBMemtoReg), 32'(pend.m2r));
            chk("wb_aluresult", WBALUResult, pend.alu);
            chk("wb_readdata", WBReadData, pend.rdat);
            chk("wb_rd", 32'(WBRegisterRd), 32'(pend.rd));
            havePend = 0;
        end
    endtask

    task automatic drive_mem(input logic rw, input logic m2r, input logic wr, input logic rd_,
                             input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rdst);
        MEMRegWrite   = rw;
        MEMMemtoReg   = m2r;
        MEMMemWrite   = wr;
        MEMMemRead    = rd_;
        MEMALUResult  = alu;
        MEMRegData2   = wd;
        MEMRegisterRd = rdst;
    endtask

    // One instruction through MEM; memory acks in REQ cycle k. Entered and left at posedge+1.
    task automatic run_op(input logic rw, input logic m2r, input logic wr, input logic rd_,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rdst,
                          input int k, input logic [31:0] rdata);
        logic memop;
        memop = rd_ | wr;
        drive_mem(rw, m2r, wr, rd_, alu, wd, rdst);
        dmem.DAck   = 1'($urandom_range(0, 1));   // must be ignored outside REQ
        dmem.DRData = $urandom;
        #1;
        check_pending();
        chk("idle_stall", 32'(Stall), 32'(memop));
        chk("idle_dreq", 32'(dmem.DReq), 32'd0);
        chk("idle_memerr", 32'(MemErr), 32'd0);
        @(posedge Clk); #1;
        if (memop) begin
            for (int i = 1; i <= k; i++) begin
                dmem.DAck   = (i == k);
                dmem.DRData = (i == k) ? rdata : $urandom;
                #1;
                chk("req_dreq", 32'(dmem.DReq), 32'd1);
                chk("req_dwe", 32'(dmem.DWe), 32'(wr));
                chk("req_daddr", dmem.DAddr, alu);
                chk("req_dwdata", dmem.DWData, wd);
                chk("req_stall", 32'(Stall), 32'(i != k));
                chk("req_bubble", 32'(WBRegWrite), 32'd0);
                chk("req_memerr", 32'(MemErr), 32'd0);
                @(posedge Clk); #1;
            end
        end
        dmem.DAck = 1'b0;
        if (memop && !wr) mRd = rdata;
        pend     = '{rw, m2r, alu, mRd, rdst};
        havePend = 1;
    endtask

    initial begin
        Rst_n       = 1'b0;
        dmem.DAck   = 1'b0;
        dmem.DRData = '0;
        drive_mem(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_dreq", 32'(dmem.DReq), 32'd0);
        chk("rst_dwe", 32'(dmem.DWe), 32'd0);
        chk("rst_daddr", dmem.DAddr, 32'd0);
        chk("rst_dwdata", dmem.DWData, 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_wbregwrite", 32'(WBRegWrite), 32'd0);
        chk("rst_wbmemtoreg", 32'(WBMemtoReg), 32'd0);
        chk("rst_wbreaddata", WBReadData, 32'd0);
        chk("rst_wbalu", WBALUResult, 32'd0);
        chk("rst_wbrd", 32'(WBRegisterRd), 32'd0);
        chk("rst_memerr", 32'(MemErr), 32'd0);
        Rst_n = 1'b1;

        // ALU op, zero-wait load, 3-wait store, back-to-back loads, write-wins.
        run_op(1, 0, 0, 0, 32'h0000_0042, 32'h0, 5'd5, 1, 32'h0);
        run_op(1, 1, 0, 1, 32'h0000_0010, 32'h0, 5'd7, 1, 32'hDEAD_BEEF);
        run_op(0, 0, 1, 0, 32'h0000_0020, 32'h1234_5678, 5'd0, 3, 32'h0);
        run_op(1, 1, 0, 1, 32'h0000_0100, 32'h0, 5'd8, 1, 32'hCAFE_0001);
        run_op(1, 1, 0, 1, 32'h0000_0104, 32'h0, 5'd9, 1, 32'hCAFE_0002);
        run_op(0, 0, 1, 1, 32'h0000_0200, 32'hA5A5_5A5A, 5'd3, 2, 32'hFFFF_FFFF);
        run_op(1, 0, 1, 0, 32'h0000_0300, 32'h0BAD_F00D, 5'd4, 1, 32'h0);

        // Reset in the 2nd REQ cycle of a load abandons it.
        drive_mem(1, 1, 0, 1, 32'h0000_0400, 32'h0, 5'd10);
        dmem.DAck = 1'b0;
        #1;
        check_pending();
        @(posedge Clk); #1;
        #1;
        chk("rst_mid_req1", 32'(dmem.DReq), 32'd1);
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        drive_mem(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        #1;
        chk("rst_mid_dreq", 32'(dmem.DReq), 32'd0);
        chk("rst_mid_stall", 32'(Stall), 32'd0);
        chk("rst_mid_wbregwrite", 32'(WBRegWrite), 32'd0);
        chk("rst_mid_wbmemtoreg", 32'(WBMemtoReg), 32'd0);
        chk("rst_mid_wbreaddata", WBReadData, 32'd0);
        chk("rst_mid_wbalu", WBALUResult, 32'd0);
        chk("rst_mid_wbrd", 32'(WBRegisterRd), 32'd0);
        mRd = '0;
        @(posedge Clk); #1;
        run_op(1, 0, 0, 0, 32'h0000_0055, 32'h0, 5'd11, 1, 32'h0);

`ifdef MEM_WB_TIMEOUT_EN
        // Load that is never acked: aborted after 4 REQ cycles with a one-cycle error pulse.
        drive_mem(1, 1, 0, 1, 32'h0000_0500, 32'h0, 5'd12);
        dmem.DAck = 1'b0;
        #1;
        check_pending();
        @(posedge Clk); #1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("tmo_dreq", 32'(dmem.DReq), 32'd1);
            chk("tmo_stall", 32'(Stall), 32'(i != 4));
            chk("tmo_bubble", 32'(WBRegWrite), 32'd0);
            chk("tmo_memerr_early", 32'(MemErr), 32'd0);
            @(posedge Clk); #1;
        end
        drive_mem(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        #1;
        chk("tmo_memerr", 32'(MemErr), 32'd1);
        chk("tmo_dreq_drop", 32'(dmem.DReq), 32'd0);
        chk("tmo_squash", 32'(WBRegWrite), 32'd0);
        chk("tmo_readdata_kept", WBReadData, mRd);
        @(posedge Clk); #1;
        #1;
        chk("tmo_memerr_pulse", 32'(MemErr), 32'd0);
        @(posedge Clk); #1;
        // Ack in the timeout cycle completes normally.
        run_op(1, 1, 0, 1, 32'h0000_0504, 32'h0, 5'd13, 4, 32'h7777_8888);
`endif

        // Randomized mix of ALU ops, loads, stores and read+write collisions.
        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic        wr, rd_;
            kind = int'($urandom_range(0, 3));
            wr   = (kind == 2) || (kind == 3);
            rd_  = (kind == 1) || (kind == 3);
            run_op(1'($urandom), 1'($urandom), wr, rd_, $urandom, $urandom, 5'($urandom),
                   int'($urandom_range(1, 4)), $urandom);
        end

        // Trailing bubble so the last op's writeback is checked.
        run_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
